rf_buffer_rd_stream: RTL and testbench
======================================

// Module: rf_buffer_rd_stream
// PURPOSE
// Read-side streamer for the dbg rf_buffer UltraRAM. On a start pulse it issues LEN
// sequential reads on one URAM port and re-times the fixed-latency read data into a
// valid/ready stream with last-beat marking. It sits directly downstream of the URAM
// (drives its port B) and feeds the regmap/debug readout path; it absorbs backpressure
// without losing in-flight data.
// PARAMETERS
// AWIDTH   12  URAM address width; also width of base_addr/len
// DWIDTH   72  data width, equal to URAM DWIDTH
// NUM_COL   9  URAM byte-write columns; ram_we width
// NBPIPE    3  URAM pipeline depth; read latency LAT = NBPIPE+2 cycles
// FIFO_AW   3  return FIFO address width; depth FD = 2**FIFO_AW, must be >= LAT (elab check)
// PORTS
// clk        in   1        clock, shared with URAM
// rst        in   1        synchronous active-high reset
// start      in   1        1-cycle pulse; starts a burst; ignored while busy=1
// base_addr  in   AWIDTH   first word address, sampled on accepted start
// len        in   AWIDTH+1 number of words, sampled on accepted start; 0 allowed
// busy       out  1        burst in progress (start accepted, final beat not yet accepted)
// done       out  1        1-cycle pulse when final beat handshakes (or len==0)
// ram_rst    out  1        = rst, to URAM output-register reset
// ram_en     out  1        URAM mem_en; high only on read-issue cycles
// ram_we     out  NUM_COL  URAM write enable; constant 0
// ram_regce  out  1        URAM output register enable; constant 1
// ram_addr   out  AWIDTH   URAM address
// ram_dout   in   DWIDTH   URAM read data
// m_tdata    out  DWIDTH   stream data
// m_tvalid   out  1        stream valid
// m_tlast    out  1        final beat of burst
// m_tready   in   1        stream ready
// BEHAVIOUR
// - Reset: busy=0, done=0, ram_en=0, ram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0; FSM IDLE;
//   FIFO, inflight counter and tag shift register cleared. Reset mid-burst abandons it;
//   URAM data still in flight is discarded (tag shift register cleared), no done pulse.
// - FSM IDLE: start & len!=0 -> ISSUE (load addr=base_addr, remaining=len, busy=1).
//   start & len==0 -> DONE for one cycle: done=1 next cycle, busy stays 0, no reads.
// - ISSUE: issue cycle when remaining!=0 and inflight+fifo_count < FD: ram_en=1, ram_addr=addr,
//   addr<=addr+1 (wraps modulo 2**AWIDTH), remaining--. remaining reaches 0 -> DRAIN.
// - DRAIN: wait until inflight==0, FIFO empty and no beat pending; final beat handshake
//   -> IDLE with done=1 that cycle's next edge (registered), busy<=0 same edge.
// - Latency tracking: LAT-deep shift register of {valid,last} tags, entry injected on issue;
//   tag at depth LAT pushes ram_dout into FIFO in the same cycle ram_dout is valid.
//   last tag set on the issue with remaining==1.
// - Credit rule guarantees FIFO never overflows: push with full is an assertion failure.
// - Output: m_tdata/m_tlast driven from FIFO head, m_tvalid = !empty; pop on tvalid&tready.
//   tdata/tlast stable while tvalid & !tready. Simultaneous push+pop allowed, also when full.
// - Throughput: with m_tready held 1, one read issued per cycle, one beat per cycle after
//   LAT+1 cycles first-beat latency (start edge -> first tvalid).
// - inflight = issued-not-yet-pushed, width clog2(LAT+1); inc on issue, dec on tag arrival,
//   both same cycle -> unchanged.
// STRUCTURE
// - rf_buffer_pkg: LAT function of NBPIPE, state enum {IDLE,ISSUE,DRAIN,DONE}, tag struct
//   {valid,last}.
// - Sub-module rf_buffer_rd_fifo: synchronous first-word-fall-through FIFO, DWIDTH+1 wide,
//   2**FIFO_AW deep, full/empty/count outputs, sync reset.
// - Top: FSM, address/remaining counters, credit logic, tag shift register.
// TESTING (bench uses behavioural URAM model with NBPIPE=3, mem[i]=i)
// - Reset then start base=0x010 len=4, tready=1 -> tdata 0x10..0x13, tlast on 4th, done 1 pulse.
// - len=0 start -> done pulses once, ram_en never asserted, tvalid stays 0.
// - base=0xFFE len=4 -> addresses 0xFFE,0xFFF,0x000,0x001; data in same order.
// - len=64, tready random 30% -> all 64 words in order, no FIFO overflow, ram_en drops when
//   inflight+count==8.
// - start pulsed while busy -> ignored; burst result unchanged.
// - rst asserted mid-burst (after 5 issues) -> all outputs reset next edge; following
//   start base=0 len=2 yields exactly data 0,1 with no stale beats.

Source files
------------

// File: rtl/rf_buffer_rd_stream_pkg.sv
// Shared types and helpers for the rf_buffer URAM read streamer.
// The read latency helper mirrors the URAM's NBPIPE output pipelining.
package rf_buffer_rd_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // URAM read path: array read register + NBPIPE pipeline stages + output register
    function automatic int rd_latency(input int nbpipe);
        return nbpipe + 2;
    endfunction

endpackage

// File: rtl/rf_buffer_rd_stream_if.sv
// Valid/ready beat stream carrying URAM words plus a last-beat marker.
interface rf_buffer_rd_stream_if #(
    parameter int DWIDTH = 72
) ();

    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/rf_buffer_rd_stream_fifo.sv
// First-word-fall-through return FIFO; the head word is visible on rd_data whenever !empty.
// Pointers carry one extra bit so full and empty are distinguishable without a separate flag.
module rf_buffer_rd_stream_fifo #(
    parameter int WIDTH = 73,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only honoured when the head leaves in the same cycle
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = count[AW];
        empty    = (count == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/rf_buffer_rd_stream.sv
// Streams LEN sequential URAM words out as a valid/ready burst with tlast on the final beat.
// Reads are credited against return-FIFO space so backpressure never drops in-flight data.
module rf_buffer_rd_stream
    import rf_buffer_rd_stream_pkg::*;
#(
    parameter int AWIDTH  = 12,
    parameter int DWIDTH  = 72,
    parameter int NUM_COL = 9,
    parameter int NBPIPE  = 3,
    parameter int FIFO_AW = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AWIDTH-1:0]      base_addr,
    input  logic [AWIDTH:0]        len,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_rst,
    output logic                   ram_en,
    output logic [NUM_COL-1:0]     ram_we,
    output logic                   ram_regce,
    output logic [AWIDTH-1:0]      ram_addr,
    input  logic [DWIDTH-1:0]      ram_dout,
    rf_buffer_rd_stream_if.master  m
);

    localparam int LAT = rd_latency(NBPIPE);
    localparam int FD  = 2 ** FIFO_AW;
    localparam int IW  = $clog2(LAT + 1);
    localparam int SW  = FIFO_AW + 2;

    if (FD < LAT) begin : g_fifo_depth_check
        $error("rf_buffer_rd_stream: return FIFO depth must cover the URAM read latency");
    end

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [AWIDTH:0]     remaining_q, remaining_d;
    logic [IW-1:0]       inflight_q, inflight_d;
    tag_t [LAT-1:0]      tag_q, tag_d;
    logic                done_q, done_d;

    logic                issue;
    logic                arrive;
    logic                credit_ok;
    logic [SW-1:0]       outstanding;
    logic                pop;
    logic                head_last;
    logic [DWIDTH:0]     fifo_wr_data;
    logic [DWIDTH:0]     fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_AW:0]    fifo_count;

    // Every word issued but not yet popped holds a FIFO slot in reserve
    always_comb begin
        outstanding  = SW'(inflight_q) + SW'(fifo_count);
        credit_ok    = (outstanding < SW'(FD));
        arrive       = tag_q[LAT-1].valid;
        fifo_wr_data = {tag_q[LAT-1].last, ram_dout};
        head_last    = fifo_rd_data[DWIDTH];
        pop          = !fifo_empty && m.tready;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        addr_d      = base_addr;
                        remaining_d = len;
                    end
                end
            end
            ISSUE: begin
                if (remaining_q != '0 && credit_ok) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + AWIDTH'(1);
                    remaining_d = remaining_q - (AWIDTH + 1)'(1);
                    if (remaining_q == (AWIDTH + 1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags ride alongside the URAM pipeline so the FIFO push lines up with valid ram_dout
    always_comb begin
        tag_d      = {tag_q[LAT-2:0], tag_t'{valid: issue, last: issue && (remaining_q == (AWIDTH + 1)'(1))}};
        inflight_d = inflight_q + IW'(issue) - IW'(arrive);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            tag_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            done_q      <= done_d;
        end
    end

    rf_buffer_rd_stream_fifo #(
        .WIDTH (DWIDTH + 1),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (arrive),
        .wr_data (fifo_wr_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(arrive && fifo_full))
        else $error("rf_buffer_rd_stream: return FIFO overflow");

    always_comb begin
        busy      = (state_q == ISSUE) || (state_q == DRAIN);
        done      = done_q;
        ram_rst   = rst;
        ram_en    = issue;
        ram_we    = '0;
        ram_regce = 1'b1;
        ram_addr  = addr_q;
        m.tvalid  = !fifo_empty;
        m.tdata   = fifo_empty ? '0 : fifo_rd_data[DWIDTH-1:0];
        m.tlast   = !fifo_empty && head_last;
    end

endmodule

// File: tb/tb_rf_buffer_rd_stream.sv
// Directed bench for rf_buffer_rd_stream against a behavioural URAM holding mem[i] = i.
// Inputs change 1ns after the rising edge; all observation happens on the falling edge.
module tb_rf_buffer_rd_stream;

    localparam int AWIDTH  = 12;
    localparam int DWIDTH  = 72;
    localparam int NUM_COL = 9;
    localparam int NBPIPE  = 3;
    localparam int FIFO_AW = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [AWIDTH-1:0]   base_addr;
    logic [AWIDTH:0]     len;
    logic                busy;
    logic                done;
    logic                ram_rst;
    logic                ram_en;
    logic [NUM_COL-1:0]  ram_we;
    logic                ram_regce;
    logic [AWIDTH-1:0]   ram_addr;
    logic [DWIDTH-1:0]   ram_dout;
    logic                ready_r = 1'b1;
    int                  ready_mode = 0;

    int checks   = 0;
    int failures = 0;

    logic [AWIDTH-1:0]   addr_log [$];
    logic [DWIDTH:0]     beat_log [$];
    int done_cnt, issued, popped, max_out, viol, busy_seen, tvalid_seen;

    always #5 clk = ~clk;

    rf_buffer_rd_stream_if #(.DWIDTH(DWIDTH)) s_if ();
    assign s_if.tready = ready_r;

    rf_buffer_rd_stream #(
        .AWIDTH  (AWIDTH),
        .DWIDTH  (DWIDTH),
        .NUM_COL (NUM_COL),
        .NBPIPE  (NBPIPE),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_rst   (ram_rst),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_regce (ram_regce),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m         (s_if)
    );

    // URAM model: read register, three pipeline stages, output register -> five-edge latency
    logic [DWIDTH-1:0] rd_r;
    logic [DWIDTH-1:0] pipe_r [3];
    always @(posedge clk) begin
        if (ram_en) rd_r <= {{(DWIDTH-AWIDTH){1'b0}}, ram_addr};
        pipe_r[0] <= rd_r;
        pipe_r[1] <= pipe_r[0];
        pipe_r[2] <= pipe_r[1];
        ram_dout  <= ram_rst ? '0 : pipe_r[2];
    end

    // Sink readiness: 0 = always ready, 1 = ready about 30% of cycles
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) ready_r = ($urandom_range(0, 99) < 30);
        else                 ready_r = 1'b1;
    end

    // Observer: logs issued addresses and accepted beats, tracks issued-minus-popped credit
    always @(negedge clk) begin
        if (rst) begin
            issued = 0;
            popped = 0;
        end else begin
            if (ram_en) begin
                if (issued - popped >= 8) viol++;
                addr_log.push_back(ram_addr);
                issued++;
            end
            if (s_if.tvalid && s_if.tready) begin
                beat_log.push_back({s_if.tlast, s_if.tdata});
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) done_cnt++;
            if (busy) busy_seen++;
            if (s_if.tvalid) tvalid_seen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [DWIDTH:0] observed, input logic [DWIDTH:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [AWIDTH-1:0] b, input logic [AWIDTH:0] l);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic clearMonitors();
        addr_log.delete();
        beat_log.delete();
        done_cnt    = 0;
        max_out     = 0;
        viol        = 0;
        busy_seen   = 0;
        tvalid_seen = 0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, (DWIDTH+1)'(done_cnt != 0), (DWIDTH+1)'(1));
    endtask

    // Expected burst: address base+i (12-bit wrap), data equal to that address, last on final beat
    task automatic checkBurst(input string tag, input logic [AWIDTH-1:0] base, input int n);
        logic [AWIDTH-1:0] a;
        checkOutput({tag, "_beat_count"}, (DWIDTH+1)'(beat_log.size()), (DWIDTH+1)'(n));
        checkOutput({tag, "_addr_count"}, (DWIDTH+1)'(addr_log.size()), (DWIDTH+1)'(n));
        for (int i = 0; i < n; i++) begin
            a = base + AWIDTH'(i);
            if (i < addr_log.size())
                checkOutput($sformatf("%s_addr%0d", tag, i), (DWIDTH+1)'(addr_log[i]), (DWIDTH+1)'(a));
            if (i < beat_log.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), (DWIDTH+1)'(beat_log[i][DWIDTH-1:0]), (DWIDTH+1)'(a));
                checkOutput($sformatf("%s_last%0d", tag, i), (DWIDTH+1)'(beat_log[i][DWIDTH]), (DWIDTH+1)'(i == n - 1));
            end
        end
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        clearMonitors();

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",   (DWIDTH+1)'(busy),       '0);
        checkOutput("rst_done",   (DWIDTH+1)'(done),       '0);
        checkOutput("rst_ram_en", (DWIDTH+1)'(ram_en),     '0);
        checkOutput("rst_addr",   (DWIDTH+1)'(ram_addr),   '0);
        checkOutput("rst_tvalid", (DWIDTH+1)'(s_if.tvalid), '0);
        checkOutput("rst_tlast",  (DWIDTH+1)'(s_if.tlast), '0);
        checkOutput("rst_tdata",  (DWIDTH+1)'(s_if.tdata), '0);
        checkOutput("rst_we",     (DWIDTH+1)'(ram_we),     '0);
        checkOutput("rst_regce",  (DWIDTH+1)'(ram_regce),  (DWIDTH+1)'(1));
        checkOutput("rst_ram_rst",(DWIDTH+1)'(ram_rst),    (DWIDTH+1)'(1));
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic burst: first beat six cycles after the start edge, done four cycles later
        clearMonitors();
        applyStimulus(12'h010, 13'd4);
        @(negedge clk);
        checkOutput("t1_busy", (DWIDTH+1)'(busy), (DWIDTH+1)'(1));
        cyc = 0;
        while (!s_if.tvalid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t1_first_beat_latency", (DWIDTH+1)'(cyc), (DWIDTH+1)'(6));
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t1_start_to_done", (DWIDTH+1)'(cyc), (DWIDTH+1)'(10));
        waitCycles(5);
        checkOutput("t1_done_pulses", (DWIDTH+1)'(done_cnt), (DWIDTH+1)'(1));
        checkOutput("t1_busy_after", (DWIDTH+1)'(busy), '0);
        checkBurst("t1", 12'h010, 4);

        // Zero-length request: immediate done, no reads, no beats, never busy
        clearMonitors();
        applyStimulus(12'h123, 13'd0);
        @(negedge clk);
        checkOutput("t2_done_now", (DWIDTH+1)'(done), (DWIDTH+1)'(1));
        checkOutput("t2_busy_now", (DWIDTH+1)'(busy), '0);
        waitCycles(10);
        checkOutput("t2_done_pulses", (DWIDTH+1)'(done_cnt), (DWIDTH+1)'(1));
        checkOutput("t2_reads", (DWIDTH+1)'(addr_log.size()), '0);
        checkOutput("t2_tvalid_cycles", (DWIDTH+1)'(tvalid_seen), '0);
        checkOutput("t2_busy_cycles", (DWIDTH+1)'(busy_seen), '0);

        // Address wrap at the top of the URAM
        clearMonitors();
        applyStimulus(12'hFFE, 13'd4);
        waitDone("t3_done_seen", 100);
        waitCycles(3);
        checkBurst("t3", 12'hFFE, 4);
        checkOutput("t3_done_pulses", (DWIDTH+1)'(done_cnt), (DWIDTH+1)'(1));

        // Long burst under heavy backpressure: credit must cap outstanding words at 8
        clearMonitors();
        ready_mode = 1;
        applyStimulus(12'h100, 13'd64);
        waitDone("t4_done_seen", 3000);
        ready_mode = 0;
        waitCycles(3);
        checkBurst("t4", 12'h100, 64);
        checkOutput("t4_credit_violations", (DWIDTH+1)'(viol), '0);
        checkOutput("t4_max_outstanding", (DWIDTH+1)'(max_out), (DWIDTH+1)'(8));
        checkOutput("t4_done_pulses", (DWIDTH+1)'(done_cnt), (DWIDTH+1)'(1));

        // Start while busy is ignored
        clearMonitors();
        applyStimulus(12'h200, 13'd6);
        waitCycles(2);
        checkOutput("t5_busy", (DWIDTH+1)'(busy), (DWIDTH+1)'(1));
        applyStimulus(12'h300, 13'd3);
        waitDone("t5_done_seen", 100);
        waitCycles(10);
        checkBurst("t5", 12'h200, 6);
        checkOutput("t5_done_pulses", (DWIDTH+1)'(done_cnt), (DWIDTH+1)'(1));

        // Reset mid-burst, then a fresh burst must carry no stale words
        clearMonitors();
        applyStimulus(12'h040, 13'd20);
        cyc = 0;
        while (addr_log.size() < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6_five_issued", (DWIDTH+1)'(addr_log.size() >= 5), (DWIDTH+1)'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_busy",   (DWIDTH+1)'(busy),        '0);
        checkOutput("t6_done",   (DWIDTH+1)'(done),        '0);
        checkOutput("t6_ram_en", (DWIDTH+1)'(ram_en),      '0);
        checkOutput("t6_addr",   (DWIDTH+1)'(ram_addr),    '0);
        checkOutput("t6_tvalid", (DWIDTH+1)'(s_if.tvalid), '0);
        checkOutput("t6_tlast",  (DWIDTH+1)'(s_if.tlast),  '0);
        checkOutput("t6_tdata",  (DWIDTH+1)'(s_if.tdata),  '0);
        checkOutput("t6_no_done", (DWIDTH+1)'(done_cnt),   '0);
        @(posedge clk);
        #1 rst = 1'b0;
        clearMonitors();
        applyStimulus(12'h000, 13'd2);
        waitDone("t6_done_seen", 100);
        waitCycles(12);
        checkBurst("t6", 12'h000, 2);
        checkOutput("t6_done_pulses", (DWIDTH+1)'(done_cnt), (DWIDTH+1)'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
